// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and seven-segment table
package bcd_pkg;

  // Largest legal value of a single BCD digit
  localparam logic [3:0] BCD_MAX = 4'd9;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment patterns {a,b,c,d,e,f,g} for digits 0..9, active-high
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Non-BCD codes cannot occur in the counter, but decode them as dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > BCD_MAX) return SEG_BLANK;
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit up/down cell with load
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] r_value;

  // Digit register: reset, then load, then increment/decrement with roll-over
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 4'd0;
    end else if (load) begin
      r_value <= (load_val > BCD_MAX) ? 4'd0 : load_val;
    end else if (inc) begin
      r_value <= (r_value == BCD_MAX) ? 4'd0 : r_value + 4'd1;
    end else if (dec) begin
      r_value <= (r_value == 4'd0) ? BCD_MAX : r_value - 4'd1;
    end
  end

  // Carry on 9->0 when counting up, borrow on 0->9 when counting down
  assign carry_out = (inc && (r_value == BCD_MAX)) || (dec && (r_value == 4'd0));
  assign value     = r_value;

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - multi-digit BCD counter with multiplexed 7-seg scan
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      UP,
  input  logic                      LOAD,
  input  logic [4*DIGITS-1:0]       LOAD_VAL,
  input  logic                      BLANK,
  output logic [4*DIGITS-1:0]       COUNT,
  output logic                      CARRY,
  output logic [$clog2(DIGITS)-1:0] SEL,
  output logic [DIGITS-1:0]         SEG_COM,
  output logic [6:0]                SEG7
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LW = $clog2(DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] SEL_LAST  = LW'(DIGITS - 1);

  logic [TW-1:0]     r_tick;
  logic [SW-1:0]     r_scan;
  logic [LW-1:0]     r_sel;
  logic              r_carry;
  logic              w_tick_hit;
  logic              w_step;
  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_dec;
  logic [DIGITS-1:0] w_cout;
  logic [3:0]        w_digit;
  logic              w_upper_zero;
  logic              w_blank;

  // A load wins over a step in the same cycle
  assign w_tick_hit = (r_tick == TICK_LAST);
  assign w_step     = EN && w_tick_hit && !LOAD;

  // Count prescaler: advances only while enabled, cleared by reset and load
  always_ff @(posedge CLK) begin
    if (RST || LOAD) begin
      r_tick <= '0;
    end else if (EN) begin
      r_tick <= w_tick_hit ? '0 : r_tick + 1'b1;
    end
  end

  // Digit chain: step enters digit 0, each carry/borrow ripples upward
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign w_inc[gi] = w_step && UP;
        assign w_dec[gi] = w_step && !UP;
      end else begin : g_upper
        assign w_inc[gi] = w_cout[gi-1] && UP;
        assign w_dec[gi] = w_cout[gi-1] && !UP;
      end
      bcd_digit u_digit (
        .clk       (CLK),
        .rst       (RST),
        .inc       (w_inc[gi]),
        .dec       (w_dec[gi]),
        .load      (LOAD),
        .load_val  (LOAD_VAL[4*gi +: 4]),
        .value     (COUNT[4*gi +: 4]),
        .carry_out (w_cout[gi])
      );
    end
  endgenerate

  // Wrap pulse: carry out of the top digit, visible the cycle after the wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_cout[DIGITS-1];
    end
  end

  // Scan prescaler and digit select, free-running regardless of EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_scan <= '0;
      r_sel  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_sel  <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Display decode: select digit, blank leading zeros above digit 0, drive commons
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(r_sel)) && (COUNT[4*i +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_blank = BLANK && (r_sel != '0) && w_upper_zero;
    w_digit = COUNT[{r_sel, 2'b00} +: 4];
    SEG7    = w_blank ? SEG_BLANK : seg_decode(w_digit);
    for (int i = 0; i < DIGITS; i++) begin
      SEG_COM[i] = (i != (DIGITS - 1 - int'(r_sel)));
    end
  end

  assign SEL   = r_sel;
  assign CARRY = r_carry;

endmodule
